// File: rtl/ks_defs_pkg.sv
// Shared constants for the Kogge-Stone accumulator and adder benches:
// FSM state encoding and default widths.
package ks_defs;

    localparam logic ST_ACCUM = 1'b0;
    localparam logic ST_HOLD  = 1'b1;

    localparam int KS_N     = 64;
    localparam int KS_CNT_W = 16;

endpackage

// File: rtl/ks_accumulator_kogge_stone.sv
// Parallel-prefix (Kogge-Stone) adder with carry-in, carry-out and signed overflow.
module KoggeStoneAdder #(
    parameter int N = 64
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic         overflowFlag
);

    localparam int LV = $clog2(N);

    logic [N-1:0] p0;
    logic [N-1:0] g;
    logic [N-1:0] p;

    // Cin is folded into bit 0's generate so every g[i] ends up as the carry out of bit i.
    always_comb begin
        p0 = A ^ B;
        g  = (A & B) | {{(N-1){1'b0}}, p0[0] & Cin};
        p  = p0;
        for (int l = 0; l < LV; l++) begin
            g = g | (p & (g << (1 << l)));
            p = p & (p << (1 << l));
        end
    end

    assign S            = p0 ^ {g[N-2:0], Cin};
    assign Cout         = g[N-1];
    assign overflowFlag = g[N-1] ^ g[N-2];

endmodule

// File: rtl/ks_accumulator.sv
// Streaming signed frame accumulator: sums add/sub operands through a
// Kogge-Stone adder and holds the frame total until the consumer takes it.
module ks_accumulator
    import ks_defs::*;
#(
    parameter int N     = KS_N,
    parameter int CNT_W = KS_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [N-1:0]     inData,
    input  logic             inSub,
    input  logic             inLast,
    output logic             outValid,
    input  logic             outReady,
    output logic [N-1:0]     outSum,
    output logic             outOverflow,
    output logic             outCarry,
    output logic [CNT_W-1:0] outCount,
    output logic             dbgState
);

    // Valid/ready: a beat transfers on any rising edge where both valid and
    // ready are high; ready never depends combinationally on valid.

    logic             state_q, state_d;
    logic [N-1:0]     acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N-1:0] add_b;
    logic [N-1:0] add_s;
    logic         add_cout;
    logic         add_ovf;
    logic         accept;
    logic         release_res;

    assign add_b = inSub ? ~inData : inData;

    KoggeStoneAdder #(.N(N)) u_adder (
        .A            (acc_q),
        .B            (add_b),
        .Cin          (inSub),
        .Cout         (add_cout),
        .S            (add_s),
        .overflowFlag (add_ovf)
    );

    assign inReady     = (state_q == ST_ACCUM);
    assign outValid    = (state_q == ST_HOLD);
    assign accept      = inValid && inReady;
    assign release_res = outValid && outReady;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        if (accept) begin
            acc_d   = add_s;
            ovf_d   = ovf_q | add_ovf;
            carry_d = add_cout;
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (inLast) begin
                state_d = ST_HOLD;
            end
        end
        if (release_res) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            carry_d = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign outSum      = acc_q;
    assign outOverflow = ovf_q;
    assign outCarry    = carry_q;
    assign outCount    = cnt_q;
    assign dbgState    = state_q;

endmodule
